// File: rtl/matrix_mac_multiplier_pkg.sv
// Shared definitions for the matrix MAC multiplier: phase encodings, the
// state enum built on them, and width helpers for the index, hold-counter
// and accumulator.
package matmul_pkg;

  localparam logic [1:0] PH_LOAD_A  = 2'd0;
  localparam logic [1:0] PH_LOAD_B  = 2'd1;
  localparam logic [1:0] PH_COMPUTE = 2'd2;
  localparam logic [1:0] PH_DISPLAY = 2'd3;

  typedef enum logic [1:0] {
    S_LOAD_A  = PH_LOAD_A,
    S_LOAD_B  = PH_LOAD_B,
    S_COMPUTE = PH_COMPUTE,
    S_DISPLAY = PH_DISPLAY
  } state_t;

  // Element index width: $clog2(N*N), at least one bit.
  function automatic int idx_w(input int n);
    return (n * n > 2) ? $clog2(n * n) : 1;
  endfunction

  // Hold counter width: $clog2(HOLD_CYCLES), at least one bit.
  function automatic int cnt_w(input int hold);
    return (hold > 1) ? $clog2(hold) : 1;
  endfunction

  // Accumulator width: a full sum of N products of two DATA_W operands.
  function automatic int acc_w(input int n, input int data_w);
    return 2 * data_w + $clog2(n);
  endfunction

endpackage

// File: rtl/matrix_mac_multiplier_if.sv
// Board-side I/O bundle of the matrix multiplier: step button and switches in,
// LEDs, phase and overflow out.
interface matrix_mac_multiplier_if #(
  parameter int DATA_W = 8
);
  logic              btn;
  logic [DATA_W-1:0] switches;
  logic [DATA_W-1:0] leds;
  logic [1:0]        phase;
  logic              ovf;

  modport master (output btn, output switches, input leds, input phase, input ovf);
  modport slave  (input btn, input switches, output leds, output phase, output ovf);
endinterface

// File: rtl/matrix_mac_multiplier_btn_edge_detect.sv
// Rising-edge detector for the (already synchronised) step button. The
// previous-sample flop resets to 1 so a button held through reset does not
// register as a press when reset is released.
module btn_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);
  logic btn_q;

  // Remember last button level; reset high to swallow a held button.
  always_ff @(posedge clk) begin
    if (rst) btn_q <= 1'b1;
    else     btn_q <= btn;
  end

  assign press = btn & ~btn_q;
endmodule

// File: rtl/matrix_mac_multiplier.sv
// NxN matrix multiplier driven from switches/button, result shown on LEDs.
// A and B are loaded one element per press, C = A*B is computed with a single
// shared MAC (one multiply-accumulate per cycle), then C is stepped through
// on the LEDs.
// Optional build macro: MATMUL_SAT_EN -- saturate LEDs to all-ones when the
// displayed element overflows DATA_W; otherwise LEDs show the low bits.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   S_LOAD_A  | each press stores switches into A[idx], row-major
//   S_LOAD_B  | each press stores switches into B[idx], row-major
//   S_COMPUTE | one MAC per cycle over r, c, k; N*N*N cycles, presses ignored
//   S_DISPLAY | show C[idx]; advance on hold timeout or press
module matrix_mac_multiplier
  import matmul_pkg::*;
#(
  parameter int N           = 3,
  parameter int DATA_W      = 8,
  parameter int ACC_W       = acc_w(N, DATA_W),
  parameter int HOLD_CYCLES = 100_000_000
) (
  input logic               clk,
  input logic               rst,
  matrix_mac_multiplier_if.slave io
);

  localparam int NN    = N * N;
  localparam int IDX_W = idx_w(N);
  localparam int CNT_W = cnt_w(HOLD_CYCLES);
  localparam int RC_W  = $clog2(N);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NN - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] N_IDX    = IDX_W'(N);
  localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(N - 1);
  localparam logic [RC_W-1:0]  RC_ONE   = RC_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [DATA_W-1:0] a_mem [NN];
  logic [DATA_W-1:0] b_mem [NN];
  logic [ACC_W-1:0]  c_mem [NN];

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [RC_W-1:0]   r_q, r_d, c_q, c_d, k_q, k_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] leds_q, leds_d;
  logic              ovf_q, ovf_d;

  logic              press;
  logic              a_we, b_we, c_we;
  logic              disp_load;
  logic [IDX_W-1:0]  a_idx, b_idx, c_idx;
  logic [ACC_W-1:0]  mac_sum;
  logic [ACC_W-1:0]  c_sel;
  logic              c_sel_ovf;

  btn_edge_detect u_btn (
    .clk   (clk),
    .rst   (rst),
    .btn   (io.btn),
    .press (press)
  );

  assign a_idx   = IDX_W'(r_q) * N_IDX + IDX_W'(k_q);
  assign b_idx   = IDX_W'(k_q) * N_IDX + IDX_W'(c_q);
  assign c_idx   = IDX_W'(r_q) * N_IDX + IDX_W'(c_q);
  assign mac_sum = acc_q + ACC_W'(a_mem[a_idx]) * ACC_W'(b_mem[b_idx]);

  // Next-state, index/loop counters, MAC accumulator and display register inputs.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    r_d       = r_q;
    c_d       = c_q;
    k_d       = k_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    leds_d    = leds_q;
    ovf_d     = ovf_q;
    a_we      = 1'b0;
    b_we      = 1'b0;
    c_we      = 1'b0;
    disp_load = 1'b0;
    c_sel     = '0;
    c_sel_ovf = 1'b0;

    case (state_q)
      S_LOAD_A: begin
        if (press) begin
          a_we = 1'b1;
          if (idx_q == IDX_LAST) begin
            state_d = S_LOAD_B;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
      end
      S_LOAD_B: begin
        if (press) begin
          b_we = 1'b1;
          if (idx_q == IDX_LAST) begin
            state_d = S_COMPUTE;
            idx_d   = '0;
            r_d     = '0;
            c_d     = '0;
            k_d     = '0;
            acc_d   = '0;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
      end
      S_COMPUTE: begin
        if (k_q == RC_LAST) begin
          c_we  = 1'b1;
          acc_d = '0;
          k_d   = '0;
          if (c_q == RC_LAST) begin
            c_d = '0;
            if (r_q == RC_LAST) begin
              r_d       = '0;
              state_d   = S_DISPLAY;
              idx_d     = '0;
              cnt_d     = '0;
              disp_load = 1'b1;
            end else begin
              r_d = r_q + RC_ONE;
            end
          end else begin
            c_d = c_q + RC_ONE;
          end
        end else begin
          acc_d = mac_sum;
          k_d   = k_q + RC_ONE;
        end
      end
      S_DISPLAY: begin
        if (press || (cnt_q == CNT_LAST)) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = S_LOAD_A;
            idx_d   = '0;
            ovf_d   = 1'b0;
          end else begin
            idx_d     = idx_q + IDX_ONE;
            disp_load = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = S_LOAD_A;
    endcase

    // C[0] is complete long before the last MAC, so it can be latched on the
    // same edge that enters DISPLAY.
    if (disp_load) begin
      c_sel     = c_mem[idx_d];
      c_sel_ovf = |c_sel[ACC_W-1:DATA_W];
      ovf_d     = c_sel_ovf;
`ifdef MATMUL_SAT_EN
      leds_d    = c_sel_ovf ? '1 : c_sel[DATA_W-1:0];
`else
      leds_d    = c_sel[DATA_W-1:0];
`endif
    end
  end

  // Control and display registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LOAD_A;
      idx_q   <= '0;
      r_q     <= '0;
      c_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      leds_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      r_q     <= r_d;
      c_q     <= c_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      leds_q  <= leds_d;
      ovf_q   <= ovf_d;
    end
  end

  // Matrix storage; not cleared by reset, writes suppressed while in reset.
  always_ff @(posedge clk) begin
    if (a_we && !rst) a_mem[idx_q] <= io.switches;
    if (b_we && !rst) b_mem[idx_q] <= io.switches;
    if (c_we && !rst) c_mem[c_idx] <= mac_sum;
  end

  assign io.leds  = leds_q;
  assign io.phase = state_q;
  assign io.ovf   = ovf_q;

endmodule

// File: tb/tb_matrix_mac_multiplier.sv
// Directed bench for matrix_mac_multiplier. dut1 uses a 4-cycle hold, dut2 a
// 1000-cycle hold; both share clock, reset, button and switches.
module tb_matrix_mac_multiplier;

  localparam int NN   = 9;
  localparam int HOLD = 4;

  logic       clk;
  logic       rst;
  logic       btn;
  logic [7:0] switches;

  int n_chk = 0;
  int n_bad = 0;

  logic [7:0]  mat_a [NN];
  logic [7:0]  mat_b [NN];
  logic [17:0] exp_c [NN];

  matrix_mac_multiplier_if #(.DATA_W(8)) io1 ();
  matrix_mac_multiplier_if #(.DATA_W(8)) io2 ();

  assign io1.btn      = btn;
  assign io1.switches = switches;
  assign io2.btn      = btn;
  assign io2.switches = switches;

  matrix_mac_multiplier #(.N(3), .DATA_W(8), .HOLD_CYCLES(HOLD)) dut1 (
    .clk (clk),
    .rst (rst),
    .io  (io1)
  );

  matrix_mac_multiplier #(.N(3), .DATA_W(8), .HOLD_CYCLES(1000)) dut2 (
    .clk (clk),
    .rst (rst),
    .io  (io2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_btn();
    btn = 1'b1;
    tick();
    btn = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    btn = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic load_a();
    for (int i = 0; i < NN; i++) begin
      switches = mat_a[i];
      press_btn();
    end
  endtask

  task automatic load_b_first(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      switches = mat_b[i];
      press_btn();
    end
  endtask

  // Last B press, then count observed COMPUTE cycles (bounded).
  task automatic finish_b(input bit toggle, output int ncyc);
    switches = mat_b[NN-1];
    btn = 1'b1;
    tick();
    btn = 1'b0;
    ncyc = 0;
    while (io1.phase == 2'd2 && ncyc < 200) begin
      ncyc++;
      if (toggle) btn = ~btn;
      tick();
    end
    btn = 1'b0;
  endtask

  task automatic check_display(input string tag);
    for (int e = 0; e < NN; e++) begin
      logic [7:0] le;
      logic       oe;
      oe = (exp_c[e] > 18'd255);
`ifdef MATMUL_SAT_EN
      le = oe ? 8'hFF : exp_c[e][7:0];
`else
      le = exp_c[e][7:0];
`endif
      for (int h = 0; h < HOLD; h++) begin
        check_val({tag, "_leds"}, {24'd0, io1.leds}, {24'd0, le});
        check_val({tag, "_ovf"}, {31'd0, io1.ovf}, {31'd0, oe});
        tick();
      end
    end
    check_val({tag, "_end_phase"}, {30'd0, io1.phase}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         ncyc;
    logic [7:0] t3_led;

    rst      = 1'b1;
    btn      = 1'b0;
    switches = 8'd0;
    do_reset();

    check_val("rst_phase1", {30'd0, io1.phase}, 32'd0);
    check_val("rst_leds1",  {24'd0, io1.leds},  32'd0);
    check_val("rst_ovf1",   {31'd0, io1.ovf},   32'd0);
    check_val("rst_phase2", {30'd0, io2.phase}, 32'd0);

    // 1: identity * (1..9)
    mat_a = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
    mat_b = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    exp_c = '{18'd1, 18'd2, 18'd3, 18'd4, 18'd5, 18'd6, 18'd7, 18'd8, 18'd9};
    load_a();
    check_val("t1_phase_b", {30'd0, io1.phase}, 32'd1);
    load_b_first(NN - 1);
    finish_b(1'b0, ncyc);
    check_val("t1_compute_cycles", ncyc, 32'd27);
    check_val("t1_phase_disp", {30'd0, io1.phase}, 32'd3);
    check_display("t1");

    // 2: all twos
    do_reset();
    mat_a = '{default: 8'd2};
    mat_b = '{default: 8'd2};
    exp_c = '{default: 18'd12};
    load_a();
    load_b_first(NN - 1);
    finish_b(1'b0, ncyc);
    check_val("t2_compute_cycles", ncyc, 32'd27);
    check_display("t2");

    // 3: all 255, overflow
    do_reset();
    mat_a = '{default: 8'd255};
    mat_b = '{default: 8'd255};
    exp_c = '{default: 18'h2FA03};
    load_a();
    load_b_first(NN - 1);
    finish_b(1'b0, ncyc);
    check_val("t3_compute_cycles", ncyc, 32'd27);
    check_display("t3");
`ifdef MATMUL_SAT_EN
    t3_led = 8'hFF;
`else
    t3_led = 8'h03;
`endif
    check_val("t3_leds_keep", {24'd0, io1.leds}, {24'd0, t3_led});
    check_val("t3_ovf_clear", {31'd0, io1.ovf}, 32'd0);

    // 5: reset mid LOAD_B at idx 4 (leds nonzero beforehand)
    mat_a = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    mat_b = '{8'd1, 8'd1, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd2};
    exp_c = '{18'd1, 18'd3, 18'd6, 18'd4, 18'd9, 18'd12, 18'd7, 18'd15, 18'd18};
    load_a();
    load_b_first(4);
    check_val("t5_pre_phase", {30'd0, io1.phase}, 32'd1);
    rst = 1'b1;
    tick();
    check_val("t5_rst_phase", {30'd0, io1.phase}, 32'd0);
    check_val("t5_rst_leds",  {24'd0, io1.leds},  32'd0);
    check_val("t5_rst_ovf",   {31'd0, io1.ovf},   32'd0);
    rst = 1'b0;
    tick();
    load_a();
    load_b_first(NN - 1);
    finish_b(1'b0, ncyc);
    check_val("t5_compute_cycles", ncyc, 32'd27);
    check_display("t5");

    // 4: button held 10 cycles gives one capture; toggling in COMPUTE ignored
    do_reset();
    mat_a = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
    mat_b = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    exp_c = '{18'd9, 18'd8, 18'd7, 18'd6, 18'd5, 18'd4, 18'd3, 18'd2, 18'd1};
    switches = mat_a[0];
    btn = 1'b1;
    repeat (10) tick();
    btn = 1'b0;
    tick();
    for (int i = 1; i < NN; i++) begin
      switches = mat_a[i];
      press_btn();
      if (i == NN - 2) check_val("t4_still_load_a", {30'd0, io1.phase}, 32'd0);
    end
    check_val("t4_load_b", {30'd0, io1.phase}, 32'd1);
    load_b_first(NN - 1);
    finish_b(1'b1, ncyc);
    check_val("t4_compute_cycles", ncyc, 32'd27);
    check_display("t4");

    // 6: long hold, press at idx 2 jumps to C[3] and restarts the hold count
    do_reset();
    mat_a = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    mat_b = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
    load_a();
    load_b_first(NN - 1);
    finish_b(1'b0, ncyc);
    check_val("t6_phase2", {30'd0, io2.phase}, 32'd3);
    check_val("t6_leds_c0", {24'd0, io2.leds}, 32'd1);
    press_btn();
    check_val("t6_leds_c1", {24'd0, io2.leds}, 32'd2);
    press_btn();
    check_val("t6_leds_c2", {24'd0, io2.leds}, 32'd3);
    repeat (5) tick();
    btn = 1'b1;
    tick();
    btn = 1'b0;
    check_val("t6_leds_c3", {24'd0, io2.leds}, 32'd4);
    ncyc = 0;
    while (io2.leds == 8'd4 && ncyc < 1100) begin
      ncyc++;
      tick();
    end
    check_val("t6_hold_restart", ncyc, 32'd1000);
    check_val("t6_leds_c4", {24'd0, io2.leds}, 32'd5);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
